sodor_mem_port_arbiter: RTL

// - Shares one downstream memory request port between the instruction-fetch (imem) and data (dmem)

---
 rtl/sodor_mem_pkg.sv | 22 ++
 rtl/sodor_arb_pick.sv | 29 ++
 rtl/sodor_mem_port_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sodor_mem_pkg.sv
// Shared types and constants for the Sodor memory-port arbiter slice.
// Holds the arbiter state/owner enums and the memory function/type encodings.
package sodor_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Memory function codes
  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  // Memory access size/type codes
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic {IDLE, BUSY} stateT;
  typedef enum logic {IMEM, DMEM} ownerT;

endpackage

// File: rtl/sodor_arb_pick.sv
// Two-input request selector for the memory-port arbiter.
// A lone requester always wins; on a tie the requester that was not granted
// last time wins. Holding lastGrant at IMEM turns this into fixed dmem priority.
module sodor_arb_pick
  import sodor_mem_pkg::*;
(
  input  logic       imemValid,
  input  logic       dmemValid,
  input  logic       lastGrant,
  output logic [1:0] grant
);

  // One-hot grant: bit 0 selects imem, bit 1 selects dmem
  always_comb begin
    grant = 2'b00;
    if (imemValid && dmemValid) begin
      if (lastGrant == DMEM) begin
        grant[0] = 1'b1;
      end else begin
        grant[1] = 1'b1;
      end
    end else if (dmemValid) begin
      grant[1] = 1'b1;
    end else if (imemValid) begin
      grant[0] = 1'b1;
    end
  end

endmodule

// File: rtl/sodor_mem_port_arbiter.sv
// Shares one downstream memory request port between imem and dmem of the
// 1-stage Sodor core, with one outstanding transaction and a response timeout.
// Define SODOR_ARB_RR_EN for round-robin arbitration; the default build gives
// dmem fixed priority over imem.
module sodor_mem_port_arbiter
  import sodor_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_imemPort_req_valid,
  output logic                io_imemPort_req_ready,
  input  logic [ADDR_W-1:0]   io_imemPort_req_bits_addr,
  output logic                io_imemPort_resp_valid,
  output logic [DATA_W-1:0]   io_imemPort_resp_bits_data,
  input  logic                io_dmemPort_req_valid,
  output logic                io_dmemPort_req_ready,
  input  logic [ADDR_W-1:0]   io_dmemPort_req_bits_addr,
  input  logic [DATA_W-1:0]   io_dmemPort_req_bits_data,
  input  logic                io_dmemPort_req_bits_fcn,
  input  logic [2:0]          io_dmemPort_req_bits_typ,
  output logic                io_dmemPort_resp_valid,
  output logic [DATA_W-1:0]   io_dmemPort_resp_bits_data,
  output logic                io_memPort_req_valid,
  output logic [ADDR_W-1:0]   io_memPort_req_bits_addr,
  output logic [DATA_W-1:0]   io_memPort_req_bits_data,
  output logic                io_memPort_req_bits_fcn,
  output logic [2:0]          io_memPort_req_bits_typ,
  input  logic                io_memPort_resp_valid,
  input  logic [DATA_W-1:0]   io_memPort_resp_bits_data,
  output logic [ADDR_W-1:0]   io_respAddress,
  output logic                io_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  stateT            state;
  stateT            stateNext;
  ownerT            owner;
  ownerT            winner;
  logic [CNT_W-1:0] count;
  logic [1:0]       grant;
  logic             lastGrantBit;
  logic             grantEn;
  logic             anyGrant;
  logic             respHit;
  logic             timeoutHit;

`ifdef SODOR_ARB_RR_EN
  ownerT lastGrant;

  // Remember who won the most recent grant so ties alternate
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lastGrant <= IMEM;
    end else if (anyGrant) begin
      lastGrant <= winner;
    end
  end

  assign lastGrantBit = lastGrant;
`else
  assign lastGrantBit = IMEM;
`endif

  sodor_arb_pick pickInst (
    .imemValid (io_imemPort_req_valid),
    .dmemValid (io_dmemPort_req_valid),
    .lastGrant (lastGrantBit),
    .grant     (grant)
  );

  // Grants are only offered while idle and never while reset is held
  assign grantEn  = (state == IDLE) && reset;
  assign anyGrant = grantEn && (grant != 2'b00);
  assign winner   = grant[1] ? DMEM : IMEM;

  assign io_imemPort_req_ready = grantEn && grant[0];
  assign io_dmemPort_req_ready = grantEn && grant[1];
  assign io_memPort_req_valid  = anyGrant;

  // Forward the winner's request bits; zero when nothing is granted
  always_comb begin
    io_memPort_req_bits_addr = '0;
    io_memPort_req_bits_data = '0;
    io_memPort_req_bits_fcn  = M_XRD;
    io_memPort_req_bits_typ  = 3'd0;
    if (io_dmemPort_req_ready) begin
      io_memPort_req_bits_addr = io_dmemPort_req_bits_addr;
      io_memPort_req_bits_data = io_dmemPort_req_bits_data;
      io_memPort_req_bits_fcn  = io_dmemPort_req_bits_fcn;
      io_memPort_req_bits_typ  = io_dmemPort_req_bits_typ;
    end else if (io_imemPort_req_ready) begin
      io_memPort_req_bits_addr = io_imemPort_req_bits_addr;
      io_memPort_req_bits_fcn  = M_XRD;
      io_memPort_req_bits_typ  = MT_W;
    end
  end

  // A response only counts while a transaction is outstanding; it beats the timeout
  assign respHit    = (state == BUSY) && io_memPort_resp_valid;
  assign timeoutHit = (state == BUSY) && !io_memPort_resp_valid && (count == CNT_LAST);
  assign io_timeout = timeoutHit;

  assign io_imemPort_resp_valid     = respHit && (owner == IMEM);
  assign io_dmemPort_resp_valid     = respHit && (owner == DMEM);
  assign io_imemPort_resp_bits_data = io_imemPort_resp_valid ? io_memPort_resp_bits_data : '0;
  assign io_dmemPort_resp_bits_data = io_dmemPort_resp_valid ? io_memPort_resp_bits_data : '0;

  // Next-state logic: IDLE -> BUSY on grant, BUSY -> IDLE on response or timeout
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (anyGrant) stateNext = BUSY;
      BUSY: if (respHit || timeoutHit) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Capture the owner and address of the transaction at grant time
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner          <= IMEM;
      io_respAddress <= '0;
    end else if (anyGrant) begin
      owner          <= winner;
      io_respAddress <= io_memPort_req_bits_addr;
    end
  end

  // Count busy cycles from grant; saturate at the timeout value instead of wrapping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (anyGrant) begin
      count <= '0;
    end else if ((state == BUSY) && (count != CNT_LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule
